// File: rtl/i2c_master_core.sv
// i2c_master_core: bit-level I2C master for single-register write/read
// transactions. Each bus slot is four quarters of QTR_CYC clocks, and the
// pad enables are registered from next-state values so they line up with
// the state register.
module i2c_master_core #(
  parameter int QTR_CYC = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       core_busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       ack_error,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int CW = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
  localparam logic [CW-1:0] QMAX  = CW'(QTR_CYC - 1);
  localparam logic [CW-1:0] QZERO = CW'(1'b0);
  localparam logic [CW-1:0] QONE  = CW'(1'b1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D,
    RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP
  } state_t;

  state_t        state_r, state_nx;
  logic [CW-1:0] qcnt_r, qcnt_nx;
  logic [1:0]    q_r, q_nx;
  logic [2:0]    bit_r, bit_nx;
  logic          rw_r;
  logic [6:0]    addr_r;
  logic [7:0]    reg_r, data_r, rx_r;
  logic          samp_r;
  logic          qend_s, samp_pt_s, slot_end_s, accept_s;
  logic          ack_fail_s, rd_done_s, tx_bit_s;
  logic [1:0]    lvl_s;
  logic [7:0]    addr_w_s, addr_rd_s;

  // Bus levels {scl, sda} (1 = released) for a state, quarter and data bit.
  function automatic logic [1:0] bus_level(state_t st, logic [1:0] q, logic b);
    logic [1:0] lv;
    case (st)
      IDLE: lv = 2'b11;
      START: begin
        case (q)
          2'd0, 2'd1: lv = 2'b11;
          2'd2:       lv = 2'b10;
          default:    lv = 2'b00;
        endcase
      end
      RSTART: begin
        case (q)
          2'd0:    lv = 2'b01;
          2'd1:    lv = 2'b11;
          2'd2:    lv = 2'b10;
          default: lv = 2'b00;
        endcase
      end
      STOP: begin
        case (q)
          2'd0:    lv = 2'b00;
          2'd1:    lv = 2'b10;
          default: lv = 2'b11;
        endcase
      end
      default: begin
        if ((q == 2'd0) || (q == 2'd3)) lv = {1'b0, b};
        else                            lv = {1'b1, b};
      end
    endcase
    return lv;
  endfunction

  assign qend_s     = (qcnt_r == QMAX);
  assign samp_pt_s  = qend_s && (q_r == 2'd1);
  assign slot_end_s = qend_s && (q_r == 2'd3);
  assign accept_s   = (state_r == IDLE) && data_valid;
  assign addr_w_s   = {addr_r, 1'b0};
  assign addr_rd_s  = {addr_r, 1'b1};

  // Next-state, quarter timing and bit-index sequencing.
  always_comb begin
    state_nx   = state_r;
    qcnt_nx    = qcnt_r;
    q_nx       = q_r;
    bit_nx     = bit_r;
    ack_fail_s = 1'b0;
    rd_done_s  = 1'b0;
    if (state_r == IDLE) begin
      qcnt_nx = QZERO;
      q_nx    = 2'd0;
      bit_nx  = 3'd7;
      if (data_valid) state_nx = START;
      else            state_nx = IDLE;
    end else begin
      if (qend_s) begin
        qcnt_nx = QZERO;
        q_nx    = q_r + 2'd1;
      end else begin
        qcnt_nx = qcnt_r + QONE;
      end
      if (slot_end_s) begin
        case (state_r)
          START:  state_nx = ADDR_W;
          ADDR_W: if (bit_r == 3'd0) begin state_nx = ACK_A;  bit_nx = 3'd7; end
                  else begin bit_nx = bit_r - 3'd1; end
          REG:    if (bit_r == 3'd0) begin state_nx = ACK_R;  bit_nx = 3'd7; end
                  else begin bit_nx = bit_r - 3'd1; end
          WDATA:  if (bit_r == 3'd0) begin state_nx = ACK_D;  bit_nx = 3'd7; end
                  else begin bit_nx = bit_r - 3'd1; end
          ADDR_R: if (bit_r == 3'd0) begin state_nx = ACK_AR; bit_nx = 3'd7; end
                  else begin bit_nx = bit_r - 3'd1; end
          RDATA:  if (bit_r == 3'd0) begin state_nx = MNACK;  bit_nx = 3'd7; end
                  else begin bit_nx = bit_r - 3'd1; end
          ACK_A:  if (samp_r) begin state_nx = STOP; ack_fail_s = 1'b1; end
                  else begin state_nx = REG; end
          ACK_R:  if (samp_r) begin state_nx = STOP; ack_fail_s = 1'b1; end
                  else if (rw_r) begin state_nx = RSTART; end
                  else begin state_nx = WDATA; end
          ACK_D:  begin state_nx = STOP; ack_fail_s = samp_r; end
          RSTART: state_nx = ADDR_R;
          ACK_AR: if (samp_r) begin state_nx = STOP; ack_fail_s = 1'b1; end
                  else begin state_nx = RDATA; end
          MNACK:  begin state_nx = STOP; rd_done_s = 1'b1; end
          STOP:   state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end else begin
        state_nx = state_r;
      end
    end
  end

  // Bit to present on SDA in the upcoming cycle, and the resulting pad levels.
  always_comb begin
    tx_bit_s = 1'b1;
    case (state_nx)
      ADDR_W:  tx_bit_s = addr_w_s[bit_nx];
      REG:     tx_bit_s = reg_r[bit_nx];
      WDATA:   tx_bit_s = data_r[bit_nx];
      ADDR_R:  tx_bit_s = addr_rd_s[bit_nx];
      default: tx_bit_s = 1'b1;
    endcase
    lvl_s = bus_level(state_nx, q_nx, tx_bit_s);
  end

  // State register and quarter/bit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      qcnt_r  <= QZERO;
      q_r     <= 2'd0;
      bit_r   <= 3'd7;
    end else begin
      state_r <= state_nx;
      qcnt_r  <= qcnt_nx;
      q_r     <= q_nx;
      bit_r   <= bit_nx;
    end
  end

  // Request latch; only loaded when a request is accepted from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_r   <= 1'b0;
      addr_r <= 7'd0;
      reg_r  <= 8'd0;
      data_r <= 8'd0;
    end else if (accept_s) begin
      rw_r   <= rw;
      addr_r <= slave_addr;
      reg_r  <= reg_addr;
      data_r <= reg_data;
    end
  end

  // Sample SDA on the last cycle of q1; read-data bits shift in MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_r <= 1'b0;
      rx_r   <= 8'd0;
    end else if ((state_r != IDLE) && samp_pt_s) begin
      samp_r <= sda_in;
      if (state_r == RDATA) rx_r <= {rx_r[6:0], sda_in};
    end
  end

  // Status outputs back to the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_busy <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'd0;
      ack_error <= 1'b0;
    end else begin
      core_busy <= (state_nx != IDLE);
      rd_valid  <= rd_done_s;
      if (rd_done_s) rd_data <= rx_r;
      if (accept_s)        ack_error <= 1'b0;
      else if (ack_fail_s) ack_error <= 1'b1;
    end
  end

  // Open-drain pad enables (1 = pull low).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
    end else begin
      scl_oe <= ~lvl_s[1];
      sda_oe <= ~lvl_s[0];
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core: scoreboard bench. Requests push the expected bus token
// stream (START/STOP/bit) and a transaction summary; a bus monitor with an
// embedded slave decodes the pads and compares as events occur.
module tb_i2c_master_core;
  localparam int Q    = 4;
  localparam int SLOT = 4 * Q;
  localparam int TS   = 2;   // START / repeated START token
  localparam int TP   = 3;   // STOP token

  logic       clk = 1'b0;
  logic       rst, data_valid, rw;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr, reg_data;
  logic       core_busy, rd_valid, ack_error, scl_oe, sda_oe, sda_in;
  logic [7:0] rd_data;

  logic slave_pull = 1'b0;
  logic corrupt    = 1'b0;
  assign sda_in = (~sda_oe & ~slave_pull) ^ corrupt;

  i2c_master_core #(.QTR_CYC(Q)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .rw(rw),
    .slave_addr(slave_addr), .reg_addr(reg_addr), .reg_data(reg_data),
    .core_busy(core_busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .ack_error(ack_error), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         aerr;
    int         rv;
    logic [7:0] rdd;
    int         busy;
  } txn_t;

  txn_t       exp_txn[$];
  int         exp_tok[$];
  int         checks = 0, errors = 0;
  int         ntok = 0;
  logic [7:0] model_rd = 8'h00;
  int         nack_at = 7;
  logic [7:0] sl_rdbyte = 8'h00;
  bit         sp_mode = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tok(input int v);
    if (exp_tok.size() == 0) begin
      checks++; errors++;
      $display("FAIL bus_token actual=%0d required=none", v);
    end else begin
      chk("bus_token", v, exp_tok.pop_front());
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_tok(input int v);
    exp_tok.push_back(v);
    ntok++;
  endtask

  task automatic push_byte(input logic [7:0] b, input int ack_tok);
    for (int i = 7; i >= 0; i--) push_tok(int'(b[i]));
    push_tok(ack_tok);
  endtask

  // Transaction expressed as protocol events; every event is one bus slot.
  task automatic model_push(input bit r, input logic [6:0] a, input logic [7:0] rg,
                            input logic [7:0] dt, input logic [7:0] rb, input int nk);
    txn_t t;
    bit   err;
    ntok = 0;
    err  = 1'b0;
    push_tok(TS);
    push_byte({a, 1'b0}, (nk == 0) ? 1 : 0);
    err = (nk == 0);
    if (!err) begin
      push_byte(rg, (nk == 1) ? 1 : 0);
      err = (nk == 1);
    end
    if (!err) begin
      if (!r) begin
        push_byte(dt, (nk == 2) ? 1 : 0);
        err = (nk == 2);
      end else begin
        push_tok(TS);
        push_byte({a, 1'b1}, (nk == 2) ? 1 : 0);
        err = (nk == 2);
        if (!err) push_byte(rb, 1);
      end
    end
    push_tok(TP);
    t.aerr = err;
    t.rv   = (r && !err) ? 1 : 0;
    if (t.rv == 1) model_rd = rb;
    t.rdd  = model_rd;
    t.busy = ntok * SLOT;
    exp_txn.push_back(t);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (core_busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (core_busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout actual=busy required=idle within %0d", maxc);
    end
  endtask

  task automatic issue(input bit r, input logic [6:0] a, input logic [7:0] rg,
                       input logic [7:0] dt, input logic [7:0] rb, input int nk);
    wait_idle(4000);
    nack_at   = nk;
    sl_rdbyte = rb;
    model_push(r, a, rg, dt, rb, nk);
    @(negedge clk);
    rw = r; slave_addr = a; reg_addr = rg; reg_data = dt;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // ---------------- monitor + slave model ----------------
  bit         m_scl_p = 1'b1, m_sda_p = 1'b1, m_busy_p = 1'b0;
  bit         m_pend = 1'b0, m_pv = 1'b0, m_last_bit = 1'b0;
  bit         m_rd_mode = 1'b0, m_drv = 1'b0, m_scl, m_sda;
  int         m_cyc = 0, m_rise = 0, m_bitpos = 0, m_byte = 0, m_gbyte = 0;
  int         m_bcnt = 0, m_rvcnt = 0, m_h = 0;
  logic [7:0] m_sh = 8'h00;
  txn_t       m_t;

  initial begin : monitor
    forever begin
      @(negedge clk);
      m_cyc++;
      if (rst) begin
        m_scl_p = 1'b1; m_sda_p = 1'b1; m_busy_p = 1'b0; m_pend = 1'b0;
        m_last_bit = 1'b0; m_rd_mode = 1'b0; m_drv = 1'b0;
        m_bitpos = 0; m_byte = 0; m_gbyte = 0;
        slave_pull = 1'b0; corrupt = 1'b0;
        exp_tok.delete();
        exp_txn.delete();
      end else begin
        m_scl = !scl_oe;
        m_sda = !sda_oe && !slave_pull;
        // transaction boundaries
        if (core_busy && !m_busy_p) begin
          chk("ack_error_cleared", int'(ack_error), 0);
          m_bcnt = 0; m_rvcnt = 0;
        end
        if (core_busy) begin
          m_bcnt++;
          if (rd_valid) m_rvcnt++;
        end
        if (!core_busy && m_busy_p) begin
          if (exp_txn.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_txn actual=%0d cycles required=none", m_bcnt);
          end else begin
            m_t = exp_txn.pop_front();
            chk("busy_cycles", m_bcnt, m_t.busy);
            chk("ack_error", int'(ack_error), int'(m_t.aerr));
            chk("rd_valid_pulses", m_rvcnt, m_t.rv);
            chk("rd_data", int'(rd_data), int'(m_t.rdd));
            chk("tokens_left", exp_tok.size(), 0);
          end
        end
        m_busy_p = core_busy;
        // START / STOP: SDA edge while SCL stays high
        if (m_scl_p && m_scl && m_sda_p && !m_sda) begin
          tok(TS);
          m_pend = 1'b0; m_last_bit = 1'b0;
          m_bitpos = 0; m_byte = 0; m_rd_mode = 1'b0;
        end else if (m_scl_p && m_scl && !m_sda_p && m_sda) begin
          tok(TP);
          m_pend = 1'b0; m_last_bit = 1'b0;
          m_bitpos = 0; m_byte = 0; m_gbyte = 0; m_rd_mode = 1'b0;
        end
        // SCL rise: candidate bit
        if (!m_scl_p && m_scl) begin
          if (m_last_bit) chk("scl_period", m_cyc - m_rise, SLOT);
          m_rise = m_cyc;
          m_pend = 1'b1;
          m_pv   = m_sda;
        end
        // SCL fall after a clean high phase: a bit; slave reacts
        if (m_scl_p && !m_scl && m_pend) begin
          chk("scl_high", m_cyc - m_rise, 2 * Q);
          tok(int'(m_pv));
          m_pend = 1'b0; m_last_bit = 1'b1;
          m_sh = {m_sh[6:0], m_pv};
          m_bitpos++;
          if (m_bitpos == 8) begin
            if (m_byte == 0) m_rd_mode = m_sh[0];
            if (m_rd_mode && m_byte == 1) begin
              slave_pull = 1'b0; m_drv = 1'b0;
            end else begin
              slave_pull = (m_gbyte != nack_at);
            end
          end else if (m_bitpos == 9) begin
            m_bitpos = 0; m_byte++; m_gbyte++;
            slave_pull = 1'b0;
            if (m_rd_mode && m_byte == 1) begin
              slave_pull = !sl_rdbyte[7]; m_drv = 1'b1;
            end
          end else if (m_rd_mode && m_byte == 1) begin
            slave_pull = !sl_rdbyte[7 - m_bitpos]; m_drv = 1'b1;
          end
        end
        // Optional disturbance: read bits valid only on the sample cycle
        m_h = m_cyc - m_rise;
        corrupt = sp_mode && m_drv && m_scl && (m_h != Q - 1);
        m_scl_p = m_scl;
        m_sda_p = m_sda;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin : stimulus
    bit         r;
    logic [6:0] a;
    logic [7:0] rg, dt, rb;
    int         nk;
    rst = 1'b1; data_valid = 1'b0; rw = 1'b0;
    slave_addr = 7'h00; reg_addr = 8'h00; reg_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_core_busy", int'(core_busy), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_ack_error", int'(ack_error), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_scl_oe", int'(scl_oe), 0);
    chk("rst_sda_oe", int'(sda_oe), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // register write
    issue(1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 7);
    wait_idle(4000);

    // register read; slave bits valid only at the sample cycle
    sp_mode = 1'b1;
    issue(1'b1, 7'h1D, 8'h34, 8'h00, 8'hA5, 7);
    wait_idle(4000);
    sp_mode = 1'b0;

    // address NACK
    issue(1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 0);
    wait_idle(4000);
    repeat (3) @(negedge clk);
    chk("ack_error_sticky", int'(ack_error), 1);

    // request while busy must be ignored
    issue(1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 7);
    repeat (100) @(negedge clk);
    reg_addr = 8'h55; reg_data = 8'hFF; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle(4000);
    repeat (20) @(negedge clk);
    chk("no_second_txn", int'(core_busy), 0);

    // asynchronous reset inside the REG byte
    issue(1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 7);
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_scl_oe", int'(scl_oe), 0);
    chk("abort_sda_oe", int'(sda_oe), 0);
    chk("abort_core_busy", int'(core_busy), 0);
    chk("abort_rd_data", int'(rd_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_rd = 8'h00;
    repeat (2) @(negedge clk);
    issue(1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 7);
    wait_idle(4000);

    // randomized transactions, some with NACKs
    for (int i = 0; i < 16; i++) begin
      r  = 1'($urandom_range(0, 1));
      a  = 7'($urandom);
      rg = 8'($urandom);
      dt = 8'($urandom);
      rb = 8'($urandom);
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 7;
      issue(r, a, rg, dt, rb, nk);
      wait_idle(4000);
    end

    repeat (10) @(negedge clk);
    chk("txn_queue_empty", exp_txn.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
